// File: rtl/hyperbus_pkg.sv
// Shared constants and width helpers for the Hyperbus burst front-end.
package hyperbus_pkg;

    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_READ  = 3'b010;
    localparam logic [2:0] ST_WRITE = 3'b100;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    function automatic int hb_clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

    function automatic int hb_ratio(input int fifo_w, input int hbus_w);
        return fifo_w / hbus_w;
    endfunction

    // Beat counter must hold (max burst words * ratio) - 1.
    function automatic int hb_cnt_width(input int ratio, input int burst_w);
        int w;
        w = hb_clog2(ratio * (1 << burst_w));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hyperbus_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and a
// look-ahead read port showing the entry behind the head.
module hyperbus_sync_fifo #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DSIZE-1:0] wdata,
    input  logic             pop,
    output logic [DSIZE-1:0] rdata,
    output logic [DSIZE-1:0] rdata_next,
    output logic             full,
    output logic             empty,
    output logic [ASIZE:0]   count
);
    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE-1:0] wr_ptr;
    logic [ASIZE-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count == '0);
    assign full       = (count == (ASIZE+1)'(DEPTH));
    assign do_pop     = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign do_push    = push & (~full | do_pop);
    assign rdata      = mem[rd_ptr];
    assign rdata_next = mem[rd_ptr + ASIZE'(1)];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ASIZE'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ASIZE'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (ASIZE+1)'(1);
                2'b01:   count <= count - (ASIZE+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hyperbus_burst_fifo.sv
// Command/TX/RX queueing front-end that turns user words into Hyperbus
// bursts, serialising each word MSB-first into RATIO beats.
module hyperbus_burst_fifo
    import hyperbus_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int BURST_WIDTH     = 4,
    parameter int CMD_DEPTH_LOG2  = 2,
    parameter int DATA_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [HBUS_ADDR_WIDTH-1:0] cmd_adr,
    input  logic [BURST_WIDTH-1:0]     cmd_len,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    input  logic [FIFO_DATA_WIDTH-1:0] tx_dat,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [FIFO_DATA_WIDTH-1:0] rx_dat,
    output logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_o,
    input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
    output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
    output logic                       hbus_rrq,
    output logic                       hbus_wrq,
    input  logic                       hbus_ready,
    input  logic                       hbus_valid,
    input  logic                       hbus_busy,
    output logic                       idle,
    output logic [2:0]                 dbg_state
);
    localparam int RATIO      = hb_ratio(FIFO_DATA_WIDTH, HBUS_DATA_WIDTH);
    localparam int CNT_W      = hb_cnt_width(RATIO, BURST_WIDTH);
    localparam int CMD_W      = 1 + BURST_WIDTH + HBUS_ADDR_WIDTH;
    localparam int DCW        = DATA_DEPTH_LOG2 + 1;
    localparam int DATA_DEPTH = 1 << DATA_DEPTH_LOG2;

    logic [2:0]                 state;
    logic [CNT_W-1:0]           beat_cnt;
    logic [FIFO_DATA_WIDTH-1:0] tx_sh;
    logic [FIFO_DATA_WIDTH-1:0] rx_sh;

    logic [CMD_W-1:0]           cmd_head, cmd_next;
    logic                       cmd_full, cmd_empty, cmd_pop;
    logic [CMD_DEPTH_LOG2:0]    cmd_count;
    logic [FIFO_DATA_WIDTH-1:0] tx_head, tx_next, rx_next, rx_wdata;
    logic                       tx_full, tx_empty, tx_pop;
    logic                       rx_full, rx_empty, rx_push;
    logic [DCW-1:0]             tx_count, rx_count, rx_free, need_words;

    logic                       head_write;
    logic [BURST_WIDTH-1:0]     head_len;
    logic [HBUS_ADDR_WIDTH-1:0] head_adr;
    logic                       start, word_last, final_beat, tx_beat, rx_beat;
    logic                       unused_sigs;

    // Every user channel transfers on valid & ready in the same cycle; valid
    // never waits on ready, and rx_dat is valid whenever rx_valid is high.
    assign cmd_ready = ~cmd_full;
    assign tx_ready  = ~tx_full;
    assign rx_valid  = ~rx_empty;
    assign idle      = (state == ST_IDLE) & cmd_empty;
    assign dbg_state = state;

    assign head_write = cmd_head[CMD_W-1];
    assign head_len   = cmd_head[HBUS_ADDR_WIDTH +: BURST_WIDTH];
    assign head_adr   = cmd_head[HBUS_ADDR_WIDTH-1:0];
    assign need_words = DCW'(head_len) + DCW'(1);
    assign rx_free    = DCW'(DATA_DEPTH) - rx_count;

    // Reserve the whole burst up front so neither underrun nor overflow can occur.
    assign start = (state == ST_IDLE) & ~cmd_empty & ~hbus_busy &
                   ((head_write == CMD_WRITE) ? (tx_count >= need_words)
                                              : (rx_free >= need_words));
    assign cmd_pop = start;

    assign word_last  = ((32'(beat_cnt) % RATIO) == 0);
    assign final_beat = (beat_cnt == '0);
    assign tx_beat    = (state == ST_WRITE) & hbus_ready;
    assign rx_beat    = (state == ST_READ) & hbus_valid;
    assign tx_pop     = tx_beat & word_last;
    assign rx_push    = rx_beat & word_last;
    assign rx_wdata   = FIFO_DATA_WIDTH'({rx_sh, hbus_dat_i});
    assign hbus_dat_o = (state == ST_WRITE) ? tx_sh[FIFO_DATA_WIDTH-1 -: HBUS_DATA_WIDTH] : '0;

    assign unused_sigs = ^{cmd_next, cmd_count, tx_empty, rx_full, rx_next};

    hyperbus_sync_fifo #(.DSIZE(CMD_W), .ASIZE(CMD_DEPTH_LOG2)) u_cmd_fifo (
        .clk(clk), .rst(rst),
        .push(cmd_valid & cmd_ready), .wdata({cmd_write, cmd_len, cmd_adr}),
        .pop(cmd_pop), .rdata(cmd_head), .rdata_next(cmd_next),
        .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
    );

    hyperbus_sync_fifo #(.DSIZE(FIFO_DATA_WIDTH), .ASIZE(DATA_DEPTH_LOG2)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .push(tx_valid & tx_ready), .wdata(tx_dat),
        .pop(tx_pop), .rdata(tx_head), .rdata_next(tx_next),
        .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    hyperbus_sync_fifo #(.DSIZE(FIFO_DATA_WIDTH), .ASIZE(DATA_DEPTH_LOG2)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .push(rx_push), .wdata(rx_wdata),
        .pop(rx_valid & rx_ready), .rdata(rx_dat), .rdata_next(rx_next),
        .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            hbus_rrq   <= 1'b0;
            hbus_wrq   <= 1'b0;
            hbus_adr_o <= '0;
            beat_cnt   <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        hbus_adr_o <= head_adr;
                        beat_cnt   <= CNT_W'((int'(head_len) + 1) * RATIO - 1);
                        if (head_write == CMD_WRITE) begin
                            tx_sh    <= tx_head;
                            hbus_wrq <= 1'b1;
                            state    <= ST_WRITE;
                        end else begin
                            hbus_rrq <= 1'b1;
                            state    <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (hbus_ready) begin
                        beat_cnt <= beat_cnt - CNT_W'(1);
                        // The head is popped this cycle, so the look-ahead entry becomes the new word.
                        tx_sh <= word_last ? tx_next : (tx_sh << HBUS_DATA_WIDTH);
                        if (final_beat) begin
                            hbus_wrq <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end
                ST_READ: begin
                    if (hbus_valid) begin
                        beat_cnt <= beat_cnt - CNT_W'(1);
                        rx_sh    <= rx_wdata;
                        if (final_beat) begin
                            hbus_rrq <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    hbus_rrq <= 1'b0;
                    hbus_wrq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_burst_fifo.sv
// Directed bench for hyperbus_burst_fifo: per-cycle vector table for the basic
// write and read bursts, then hand-written stall, busy, full and reset sequences.
module tb_hyperbus_burst_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_adr;
    logic [3:0]  cmd_len;
    logic        tx_valid, tx_ready;
    logic [31:0] tx_dat;
    logic        rx_valid, rx_ready;
    logic [31:0] rx_dat;
    logic [31:0] hbus_adr_o;
    logic [15:0] hbus_dat_i, hbus_dat_o;
    logic        hbus_rrq, hbus_wrq, hbus_ready, hbus_valid, hbus_busy;
    logic        idle;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    typedef struct packed {
        logic        cv;
        logic        cw;
        logic [31:0] ca;
        logic [3:0]  cl;
        logic        tv;
        logic [31:0] td;
        logic        hr;
        logic        hv;
        logic [15:0] hd;
        logic        rr;
        logic        e_wrq;
        logic        e_rrq;
        logic [15:0] e_dat;
        logic [31:0] e_adr;
        logic        e_idle;
        logic        e_rxv;
        logic [31:0] e_rxd;
    } vec_t;

    vec_t vecs[14];
    logic [31:0] wr_words[4];

    hyperbus_burst_fifo dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dat(tx_dat),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_dat(rx_dat),
        .hbus_adr_o(hbus_adr_o), .hbus_dat_i(hbus_dat_i), .hbus_dat_o(hbus_dat_o),
        .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq), .hbus_ready(hbus_ready),
        .hbus_valid(hbus_valid), .hbus_busy(hbus_busy), .idle(idle),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // drivers and checker
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [3:0] l);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_adr   = a;
        cmd_len   = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic push_tx(input logic [31:0] d);
        tx_valid = 1'b1;
        tx_dat   = d;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_req(input logic wr, input string name);
        for (int i = 0; i < 20; i++) begin
            if (wr ? hbus_wrq : hbus_rrq) break;
            tick();
        end
        check(name, wr ? hbus_wrq : hbus_rrq, 1);
    endtask

    // Serves n read beats (base, base+1, ...) and queues the words they form.
    task automatic read_beats(input int n, input logic [15:0] base);
        logic [15:0] prev;
        prev = '0;
        for (int i = 0; i < n; i++) begin
            hbus_valid = 1'b1;
            hbus_dat_i = base + 16'(i);
            check("rd rrq held", hbus_rrq, 1);
            if (i % 2 == 1) exp_q.push_back({prev, hbus_dat_i});
            prev = hbus_dat_i;
            tick();
        end
        hbus_valid = 1'b0;
        check("rd rrq drop", hbus_rrq, 0);
    endtask

    task automatic drain_rx(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            check(name, rx_valid, 1);
            if (exp_q.size() > 0) check(name, rx_dat, exp_q.pop_front());
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 32'h100, 4'd0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 16'h0,    32'h0,   1'b1, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,   4'd0, 1'b0, 32'h0,        1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 16'h0,    32'h0,   1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,   4'd0, 1'b0, 32'h0,        1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0, 16'hDEAD, 32'h100, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,   4'd0, 1'b0, 32'h0,        1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0, 16'hBEEF, 32'h100, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,   4'd0, 1'b0, 32'h0,        1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 16'h0,    32'h100, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h200, 4'd1, 1'b0, 32'h0,        1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 16'h0,    32'h100, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,   4'd0, 1'b0, 32'h0,        1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 16'h0,    32'h100, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,   4'd0, 1'b0, 32'h0,        1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b1, 16'h0,    32'h200, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,   4'd0, 1'b0, 32'h0,        1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h0,    32'h200, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,   4'd0, 1'b0, 32'h0,        1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 16'h0,    32'h200, 1'b0, 1'b1, 32'h11112222};
        vecs[10] = '{1'b0, 1'b0, 32'h0,   4'd0, 1'b0, 32'h0,        1'b0, 1'b1, 16'h4444, 1'b0, 1'b0, 1'b1, 16'h0,    32'h200, 1'b0, 1'b1, 32'h11112222};
        vecs[11] = '{1'b0, 1'b0, 32'h0,   4'd0, 1'b0, 32'h0,        1'b0, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 16'h0,    32'h200, 1'b1, 1'b1, 32'h11112222};
        vecs[12] = '{1'b0, 1'b0, 32'h0,   4'd0, 1'b0, 32'h0,        1'b0, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 16'h0,    32'h200, 1'b1, 1'b1, 32'h33334444};
        vecs[13] = '{1'b0, 1'b0, 32'h0,   4'd0, 1'b0, 32'h0,        1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 16'h0,    32'h200, 1'b1, 1'b0, 32'h0};

        wr_words[0] = 32'h01234567;
        wr_words[1] = 32'h89ABCDEF;
        wr_words[2] = 32'hCAFEF00D;
        wr_words[3] = 32'h13579BDF;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_adr = '0; cmd_len = '0;
        tx_valid = 1'b0; tx_dat = '0; rx_ready = 1'b0;
        hbus_dat_i = '0; hbus_ready = 1'b0; hbus_valid = 1'b0; hbus_busy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst wrq", hbus_wrq, 0);
        check("rst rrq", hbus_rrq, 0);
        check("rst adr", hbus_adr_o, 0);
        check("rst dat_o", hbus_dat_o, 0);
        check("rst rx_valid", rx_valid, 0);
        check("rst cmd_ready", cmd_ready, 1);
        check("rst tx_ready", tx_ready, 1);
        check("rst idle", idle, 1);
        check("rst state", dbg_state, 3'b001);

        // Plan items 1 and 2: single-word write, two-word read.
        for (int i = 0; i < 14; i++) begin
            cmd_valid = vecs[i].cv; cmd_write = vecs[i].cw;
            cmd_adr = vecs[i].ca; cmd_len = vecs[i].cl;
            tx_valid = vecs[i].tv; tx_dat = vecs[i].td;
            hbus_ready = vecs[i].hr; hbus_valid = vecs[i].hv;
            hbus_dat_i = vecs[i].hd; rx_ready = vecs[i].rr;
            #1;
            check($sformatf("vec%0d wrq", i), hbus_wrq, vecs[i].e_wrq);
            check($sformatf("vec%0d rrq", i), hbus_rrq, vecs[i].e_rrq);
            check($sformatf("vec%0d dat_o", i), hbus_dat_o, vecs[i].e_dat);
            check($sformatf("vec%0d adr", i), hbus_adr_o, vecs[i].e_adr);
            check($sformatf("vec%0d idle", i), idle, vecs[i].e_idle);
            check($sformatf("vec%0d rx_valid", i), rx_valid, vecs[i].e_rxv);
            if (vecs[i].e_rxv) check($sformatf("vec%0d rx_dat", i), rx_dat, vecs[i].e_rxd);
            tick();
        end
        cmd_valid = 1'b0; tx_valid = 1'b0; hbus_valid = 1'b0; rx_ready = 1'b0;

        // Plan item 3: write of 4 words waits until all TX data is queued.
        hbus_ready = 1'b1;
        push_cmd(1'b1, 32'h300, 4'd3);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({16'h0, wr_words[i][31:16]});
            exp_q.push_back({16'h0, wr_words[i][15:0]});
            push_tx(wr_words[i]);
        end
        for (int i = 0; i < 5; i++) begin
            check("t3 wrq stalled", hbus_wrq, 0);
            check("t3 idle stalled", idle, 0);
            tick();
        end
        for (int i = 2; i < 4; i++) begin
            exp_q.push_back({16'h0, wr_words[i][31:16]});
            exp_q.push_back({16'h0, wr_words[i][15:0]});
            push_tx(wr_words[i]);
        end
        check("t3 wrq before start", hbus_wrq, 0);
        tick();
        check("t3 wrq latency", hbus_wrq, 1);
        check("t3 adr", hbus_adr_o, 32'h300);
        begin
            int beats;
            beats = 0;
            while (hbus_wrq && beats < 20) begin
                if (exp_q.size() > 0) check("t3 beat", hbus_dat_o, exp_q.pop_front());
                beats++;
                tick();
            end
            check("t3 beat count", beats, 8);
        end
        check("t3 queue drained", exp_q.size(), 0);
        check("t3 idle after", idle, 1);

        // Plan item 4: RX holds 15 words, 2-word read stalls until one is popped.
        push_cmd(1'b0, 32'h400, 4'd14);
        wait_req(1'b0, "t4 fill rrq");
        read_beats(30, 16'h1000);
        push_cmd(1'b0, 32'h500, 4'd1);
        for (int i = 0; i < 5; i++) begin
            check("t4 rrq stalled", hbus_rrq, 0);
            tick();
        end
        drain_rx(1, "t4 pop one");
        wait_req(1'b0, "t4 rrq after pop");
        check("t4 adr", hbus_adr_o, 32'h500);
        read_beats(4, 16'h2000);
        drain_rx(16, "t4 drain");
        check("t4 rx empty", rx_valid, 0);

        // Plan item 5: busy holds off a start; busy mid-burst is ignored.
        hbus_busy = 1'b1;
        push_cmd(1'b0, 32'h600, 4'd0);
        for (int i = 0; i < 4; i++) begin
            check("t5 rrq while busy", hbus_rrq, 0);
            tick();
        end
        hbus_busy = 1'b0;
        tick();
        check("t5 rrq after busy", hbus_rrq, 1);
        hbus_busy = 1'b1;
        read_beats(2, 16'h3000);
        drain_rx(1, "t5 word");
        for (int i = 0; i < 4; i++) begin
            check("t5 cmd_ready before full", cmd_ready, 1);
            push_cmd(1'b0, 32'h700 + 32'(i), 4'd0);
        end
        check("t5 cmd_ready full", cmd_ready, 0);
        check("t5 idle full", idle, 0);
        check("t5 rrq full", hbus_rrq, 0);

        // Plan item 6: reset during beat 3 of an 8-beat write.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hbus_busy = 1'b0;
        tick();
        check("t6 cmd_ready after clear", cmd_ready, 1);
        for (int i = 0; i < 4; i++) push_tx(wr_words[i]);
        push_cmd(1'b1, 32'h800, 4'd3);
        wait_req(1'b1, "t6 wrq");
        tick();
        tick();
        check("t6 beat3 data", hbus_dat_o, wr_words[1][31:16]);
        rst = 1'b1;
        tick();
        check("t6 wrq dropped", hbus_wrq, 0);
        check("t6 dat_o", hbus_dat_o, 0);
        check("t6 adr", hbus_adr_o, 0);
        check("t6 tx_ready", tx_ready, 1);
        check("t6 rx_valid", rx_valid, 0);
        check("t6 cmd_ready", cmd_ready, 1);
        check("t6 idle", idle, 1);
        rst = 1'b0;
        push_cmd(1'b1, 32'h900, 4'd0);
        for (int i = 0; i < 5; i++) begin
            check("t6 tx flushed", hbus_wrq, 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
